// File: rtl/pedometer_pkg.sv
// Shared definitions for the multi-channel pedometer: FSM encoding, weight-file
// slot indices and width helpers.
package pedometer_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HID  = 2'd1,
      S_OUT  = 2'd2,
      S_WB   = 2'd3
   } state_t;

   localparam int NUM_W  = 8;
   localparam int NUM_SNAP = 7;

   localparam int THETA1 = 0;
   localparam int THETA2 = 1;
   localparam int BETA1  = 2;
   localparam int BETA2  = 3;
   localparam int ALPHA1 = 4;
   localparam int ALPHA2 = 5;
   localparam int THRESH = 6;
   localparam int RSVD   = 7;

   function automatic int ch_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int hid_width(input int dw);
      return 2 * dw + 1;
   endfunction

   function automatic int score_width(input int dw);
      return 3 * dw + 2;
   endfunction

endpackage

// File: rtl/ped_weight_file.sv
// Eight-entry weight register file with two write ports; port 2 wins when both
// ports write the same slot in the same cycle.
module ped_weight_file
   import pedometer_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr1_en,
   input  logic [2:0]        addr1,
   input  logic [DATA_W-1:0] data1,
   input  logic              wr2_en,
   input  logic [2:0]        addr2,
   input  logic [DATA_W-1:0] data2,
   output logic [DATA_W-1:0] weights [NUM_W]
);

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_W; i++) begin
            weights[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_W; i++) begin
            if (wr2_en && (addr2 == 3'(i))) begin
               weights[i] <= data2;
            end else if (wr1_en && (addr1 == 3'(i))) begin
               weights[i] <= data1;
            end
         end
      end
   end

endmodule

// File: rtl/multi_pedometer.sv
// Multi-channel step detector: two-neuron score per sample, thresholded into
// saturating per-channel step counters. Define PEDO_EDGE_DETECT_EN to count rising detections only.
module multi_pedometer
   import pedometer_pkg::*;
#(
   parameter  int DATA_W = 8,
   parameter  int NUM_CH = 4,
   parameter  int CNT_W  = 16,
   localparam int CH_W   = ch_width(NUM_CH)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [CH_W-1:0]         in_ch,
   input  logic [DATA_W-1:0]       A,
   input  logic [DATA_W-1:0]       B,
   input  logic                    wr1_en,
   input  logic [2:0]              Addr1,
   input  logic [DATA_W-1:0]       Data1,
   input  logic                    wr2_en,
   input  logic [2:0]              Addr2,
   input  logic [DATA_W-1:0]       Data2,
   input  logic                    clr_ch_en,
   input  logic [CH_W-1:0]         clr_ch,
   output logic                    step_pulse,
   output logic [CH_W-1:0]         step_ch,
   output logic [NUM_CH*CNT_W-1:0] step_count,
   output logic                    busy
);

   localparam int HID_W   = hid_width(DATA_W);
   localparam int SCORE_W = score_width(DATA_W);

   state_t state, state_nx;

   logic [DATA_W-1:0]  wts [NUM_W];
   logic               unused_rsvd;

   logic [CH_W-1:0]    ch_p0;
   logic [DATA_W-1:0]  a_p0, b_p0;
   logic [DATA_W-1:0]  snap_p0 [NUM_SNAP];
   logic [HID_W-1:0]   h1_p1, h2_p1;
   logic [SCORE_W-1:0] score, thr_ext;
   logic               det_p2;

   logic [CNT_W-1:0]   cnt [NUM_CH];
   logic               accept, ch_ok, step_hit;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + CNT_W'(1);
   endfunction

   ped_weight_file #(.DATA_W(DATA_W)) u_wf (
      .clk     (clk),
      .reset   (reset),
      .wr1_en  (wr1_en),
      .addr1   (Addr1),
      .data1   (Data1),
      .wr2_en  (wr2_en),
      .addr2   (Addr2),
      .data2   (Data2),
      .weights (wts)
   );

   // The reserved slot is writable but has no function.
   assign unused_rsvd = ^wts[RSVD];

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (accept) state_nx = S_HID;
         S_HID:   state_nx = S_OUT;
         S_OUT:   state_nx = S_WB;
         S_WB:    state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready   = 1'b0;
      busy       = 1'b0;
      step_pulse = 1'b0;
      step_ch    = '0;
      if (!reset) begin
         in_ready   = (state == S_IDLE);
         busy       = (state != S_IDLE);
         step_pulse = step_hit;
         step_ch    = step_hit ? ch_p0 : '0;
      end
   end

   assign accept = in_valid && in_ready;
   assign ch_ok  = (32'(ch_p0) < NUM_CH);

   // Stage p0: capture sample and freeze the weights for the whole transaction.
   always_ff @(posedge clk) begin
      if (accept) begin
         ch_p0 <= in_ch;
         a_p0  <= A;
         b_p0  <= B;
         for (int i = 0; i < NUM_SNAP; i++) begin
            snap_p0[i] <= wts[i];
         end
      end
   end

   // Stage p1: hidden neurons.
   always_ff @(posedge clk) begin
      if (state == S_HID) begin
         h1_p1 <= HID_W'(snap_p0[THETA1]) * HID_W'(a_p0) + HID_W'(snap_p0[BETA1]);
         h2_p1 <= HID_W'(snap_p0[THETA2]) * HID_W'(b_p0) + HID_W'(snap_p0[BETA2]);
      end
   end

   // Stage p2: full-width score and detection against thresh scaled by 2^DATA_W.
   always_comb begin
      score   = SCORE_W'(snap_p0[ALPHA1]) * SCORE_W'(h1_p1)
              + SCORE_W'(snap_p0[ALPHA2]) * SCORE_W'(h2_p1);
      thr_ext = SCORE_W'(snap_p0[THRESH]) << DATA_W;
   end

   always_ff @(posedge clk) begin
      if (state == S_OUT) begin
         det_p2 <= (score >= thr_ext);
      end
   end

`ifdef PEDO_EDGE_DETECT_EN
   logic [NUM_CH-1:0] prev_det;

   always_ff @(posedge clk) begin
      if (reset) begin
         prev_det <= '0;
      end else if ((state == S_WB) && ch_ok) begin
         prev_det[ch_p0] <= det_p2;
      end
   end

   assign step_hit = (state == S_WB) && det_p2 && ch_ok && !prev_det[ch_p0];
`else
   assign step_hit = (state == S_WB) && det_p2 && ch_ok;
`endif

   // Write-back: a clear on the same channel overrides the increment.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_CH; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (clr_ch_en && (32'(clr_ch) == i)) begin
               cnt[i] <= '0;
            end else if (step_hit && (32'(ch_p0) == i)) begin
               cnt[i] <= sat_inc(cnt[i]);
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_flat
      assign step_count[g*CNT_W +: CNT_W] = cnt[g];
   end

endmodule

// File: tb/tb_multi_pedometer.sv
// Randomized and directed bench for multi_pedometer against a transaction-level
// reference model of the score, threshold, edge rule and saturating counters.
module tb_multi_pedometer;

   localparam int DATA_W = 8;
   localparam int NUM_CH = 5;
   localparam int CNT_W  = 5;
   localparam int CH_W   = 3;
   localparam int CMAX   = (1 << CNT_W) - 1;
`ifdef PEDO_EDGE_DETECT_EN
   localparam bit EDGE = 1'b1;
`else
   localparam bit EDGE = 1'b0;
`endif

   logic                    clk = 1'b0;
   logic                    reset = 1'b1;
   logic                    in_valid = 1'b0;
   logic                    in_ready;
   logic [CH_W-1:0]         in_ch = '0;
   logic [DATA_W-1:0]       A = '0, B = '0;
   logic                    wr1_en = 1'b0, wr2_en = 1'b0;
   logic [2:0]              Addr1 = '0, Addr2 = '0;
   logic [DATA_W-1:0]       Data1 = '0, Data2 = '0;
   logic                    clr_ch_en = 1'b0;
   logic [CH_W-1:0]         clr_ch = '0;
   logic                    step_pulse;
   logic [CH_W-1:0]         step_ch;
   logic [NUM_CH*CNT_W-1:0] step_count;
   logic                    busy;

   always #5 clk = ~clk;

   multi_pedometer #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_ch(in_ch), .A(A), .B(B),
      .wr1_en(wr1_en), .Addr1(Addr1), .Data1(Data1),
      .wr2_en(wr2_en), .Addr2(Addr2), .Data2(Data2),
      .clr_ch_en(clr_ch_en), .clr_ch(clr_ch),
      .step_pulse(step_pulse), .step_ch(step_ch), .step_count(step_count), .busy(busy)
   );

   int n_cmp = 0, n_fail = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int  mw [8];
   int  mc [NUM_CH];
   bit  mp [NUM_CH];
   bit  fl;
   int  age;
   int  fch;
   bit  fdet;
   int  cyc = 0;

   function automatic longint mscore(input int a, input int b, input int w [8]);
      longint h1, h2;
      h1 = longint'(w[0]) * a + w[2];
      h2 = longint'(w[1]) * b + w[3];
      return longint'(w[4]) * h1 + longint'(w[5]) * h2;
   endfunction

   function automatic bit mdet(input int a, input int b, input int w [8]);
      return mscore(a, b, w) >= (longint'(w[6]) << DATA_W);
   endfunction

   function automatic bit mqual();
      if (!fdet || fch >= NUM_CH) return 1'b0;
      if (EDGE) return !mp[fch];
      return 1'b1;
   endfunction

   always @(posedge clk) begin
      cyc++;
      if (reset) begin
         foreach (mw[i]) mw[i] = 0;
         foreach (mc[i]) mc[i] = 0;
         foreach (mp[i]) mp[i] = 1'b0;
         fl = 1'b0;
      end else begin
         if (fl && age == 3) begin
            if (mqual()) mc[fch] = (mc[fch] == CMAX) ? CMAX : mc[fch] + 1;
            if (EDGE && fch < NUM_CH) mp[fch] = fdet;
            fl = 1'b0;
         end else if (fl) begin
            age++;
         end else if (in_valid) begin
            fch  = int'(in_ch);
            fdet = mdet(int'(A), int'(B), mw);
            fl   = 1'b1;
            age  = 1;
         end
         if (clr_ch_en && int'(clr_ch) < NUM_CH) mc[clr_ch] = 0;
         if (wr1_en) mw[Addr1] = int'(Data1);
         if (wr2_en) mw[Addr2] = int'(Data2);
      end
   end

   // ---------------- per-cycle compare ----------------
   bit chk_en = 1'b0;
   int n_pulse = 0;
   int last_pulse_cyc = -1;
   int last_pulse_ch = -1;

   always @(negedge clk) begin
      if (chk_en) begin
         bit ep;
         ep = !reset && fl && age == 3 && mqual();
         chk("in_ready", 64'(in_ready), 64'(!reset && !fl));
         chk("busy", 64'(busy), 64'(!reset && fl));
         chk("step_pulse", 64'(step_pulse), 64'(ep));
         chk("step_ch", 64'(step_ch), ep ? 64'(fch) : 64'd0);
         for (int i = 0; i < NUM_CH; i++) begin
            chk($sformatf("count%0d", i), 64'(step_count[i*CNT_W +: CNT_W]), 64'(mc[i]));
         end
         if (step_pulse === 1'b1) begin
            n_pulse++;
            last_pulse_cyc = cyc;
            last_pulse_ch  = int'(step_ch);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   int acc_cyc = 0;

   function automatic int cnt_of(input int ch);
      return int'(step_count[ch*CNT_W +: CNT_W]);
   endfunction

   task automatic wr(input int addr, input int data);
      wr1_en = 1'b1; Addr1 = 3'(addr); Data1 = 8'(data);
      @(posedge clk); #1;
      wr1_en = 1'b0;
   endtask

   // mode: 0 plain, 1 thresh write in HID, 2 clear own channel in WB, 3 reset in OUT
   task automatic send(input int ch, input int a, input int b, input int mode);
      bit got;
      got = 1'b0;
      in_valid = 1'b1; in_ch = 3'(ch); A = 8'(a); B = 8'(b);
      for (int k = 0; k < 20 && !got; k++) begin
         @(negedge clk);
         if (in_ready === 1'b1) begin
            got = 1'b1;
            acc_cyc = cyc;
         end
      end
      if (!got) begin
         n_cmp++; n_fail++;
         $display("FAIL accept_timeout: in_ready never seen, expected 1");
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int s = 1; s <= 3; s++) begin
         if (mode == 1 && s == 1) begin wr1_en = 1'b1; Addr1 = 3'd6; Data1 = 8'd255; end
         if (mode == 2 && s == 3) begin clr_ch_en = 1'b1; clr_ch = 3'(ch); end
         if (mode == 3 && s == 2) reset = 1'b1;
         @(posedge clk); #1;
         wr1_en = 1'b0; clr_ch_en = 1'b0;
         if (mode == 3 && s == 2) begin
            reset = 1'b0;
            @(negedge clk);
            chk("ready_after_reset", 64'(in_ready), 64'd1);
         end
      end
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int w [8];
      int p0;
      int seq [5];
      @(posedge clk);
      chk_en = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("ready_after_init", 64'(in_ready), 64'd1);

      // model pins
      w = '{16, 0, 0, 0, 16, 0, 16, 0};
      chk("model_score16", 64'(mscore(16, 0, w)), 64'd4096);
      chk("model_score15", 64'(mscore(15, 0, w)), 64'd3840);
      chk("model_det16", 64'(mdet(16, 0, w)), 64'd1);
      chk("model_det15", 64'(mdet(15, 0, w)), 64'd0);

      @(posedge clk); #1;
      wr(0, 16); wr(4, 16); wr(6, 16);

      send(0, 16, 0, 0);
      chk("latency", 64'(last_pulse_cyc - acc_cyc), 64'd3);
      chk("pulse_ch0", 64'(last_pulse_ch), 64'd0);
      chk("cnt0_after16", 64'(cnt_of(0)), 64'd1);

      p0 = n_pulse;
      send(0, 15, 0, 0);
      chk("no_pulse_a15", 64'(n_pulse - p0), 64'd0);
      chk("cnt0_after15", 64'(cnt_of(0)), 64'd1);

      seq = '{16, 16, 16, 0, 16};
      foreach (seq[i]) send(1, seq[i], 0, 0);
      chk("cnt1_edge_seq", 64'(cnt_of(1)), EDGE ? 64'd2 : 64'd4);

      // simultaneous writes to thresh, port 2 must win (thresh=9 -> 2304)
      wr1_en = 1'b1; Addr1 = 3'd6; Data1 = 8'd5;
      wr2_en = 1'b1; Addr2 = 3'd6; Data2 = 8'd9;
      @(posedge clk); #1;
      wr1_en = 1'b0; wr2_en = 1'b0;
      p0 = n_pulse;
      send(2, 9, 0, 0);
      chk("thresh9_a9", 64'(n_pulse - p0), 64'd1);
      p0 = n_pulse;
      send(2, 8, 0, 0);
      chk("thresh9_a8", 64'(n_pulse - p0), 64'd0);
      p0 = n_pulse;
      send(3, 9, 0, 1);
      chk("inflight_thresh", 64'(n_pulse - p0), 64'd1);
      p0 = n_pulse;
      send(4, 16, 0, 0);
      chk("thresh255_a16", 64'(n_pulse - p0), 64'd0);
      wr(6, 16);

      // saturation on ch2 (counter max = 31)
      for (int k = 0; k < 29; k++) begin
         send(2, 16, 0, 0);
         if (EDGE) send(2, 0, 0, 0);
      end
      chk("cnt2_pre_sat", 64'(cnt_of(2)), 64'd30);
      p0 = n_pulse;
      send(2, 16, 0, 0);
      chk("cnt2_sat1", 64'(cnt_of(2)), 64'(CMAX));
      if (EDGE) send(2, 0, 0, 0);
      send(2, 16, 0, 0);
      chk("cnt2_sat2", 64'(cnt_of(2)), 64'(CMAX));
      chk("sat_pulses", 64'(n_pulse - p0), 64'd2);

      // out-of-range channels
      p0 = n_pulse;
      send(5, 16, 0, 0); send(6, 16, 0, 0); send(7, 16, 0, 0);
      chk("bad_ch_pulses", 64'(n_pulse - p0), 64'd0);

      // clear collides with increment on ch3
      if (EDGE) send(3, 0, 0, 0);
      send(3, 16, 0, 2);
      chk("cnt3_clear_wins", 64'(cnt_of(3)), 64'd0);

      // reset while in OUT
      p0 = n_pulse;
      send(0, 16, 0, 3);
      chk("reset_no_pulse", 64'(n_pulse - p0), 64'd0);
      chk("reset_counts", 64'(step_count), 64'd0);

      // randomized traffic
      for (int k = 0; k < 3000; k++) begin
         in_valid  = 1'($urandom_range(0, 1));
         in_ch     = 3'($urandom);
         A         = 8'($urandom);
         B         = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
         wr1_en    = ($urandom_range(0, 5) == 0);
         Addr1     = 3'($urandom);
         Data1     = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom);
         wr2_en    = ($urandom_range(0, 5) == 0);
         Addr2     = 3'($urandom);
         Data2     = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom);
         clr_ch_en = ($urandom_range(0, 15) == 0);
         clr_ch    = 3'($urandom);
         reset     = ($urandom_range(0, 299) == 0);
         @(posedge clk); #1;
      end
      in_valid = 1'b0; wr1_en = 1'b0; wr2_en = 1'b0; clr_ch_en = 1'b0; reset = 1'b0;
      repeat (6) @(posedge clk);
      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/multi_pedometer.md
MULTI_PEDOMETER -- requirements
Module: multi_pedometer

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the width of sample, weight and write-data fields.
REQ-002 Parameter NUM_CH, default 4, SHALL set the number of independent step channels; CH_W = max(1, clog2(NUM_CH)).
REQ-003 Parameter CNT_W, default 16, SHALL set the width of each per-channel step counter.
REQ-004 Port clk, input, 1: the single clock; all state SHALL change on its rising edge only.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Sample inputs SHALL be in_valid (in, 1), in_ready (out, 1), in_ch (in, CH_W), A (in, DATA_W) and B (in, DATA_W).
REQ-007 Weight-write inputs SHALL be wr1_en (in, 1), Addr1 (in, 3), Data1 (in, DATA_W), wr2_en (in, 1), Addr2 (in, 3) and Data2 (in, DATA_W).
REQ-008 Input clr_ch_en (in, 1) with clr_ch (in, CH_W) SHALL zero the selected channel's counter.
REQ-009 Output step_pulse (1) SHALL assert for one cycle for each counted step, with step_ch (CH_W) naming the channel.
REQ-010 Output step_count (NUM_CH*CNT_W) SHALL present the flattened counters, channel 0 in the LSBs; busy (1) SHALL be high whenever the FSM is not IDLE.

Function
REQ-011 The weight file SHALL hold 8 unsigned DATA_W entries: 0 theta1, 1 theta2, 2 beta1, 3 beta2, 4 alpha1, 5 alpha2, 6 thresh, 7 reserved (writable, unused).
REQ-012 A weight write SHALL take effect on the next edge, be permitted in any state, and on equal Addr1/Addr2 with both enables set, port 2 SHALL win.
REQ-013 The FSM SHALL have states IDLE, HID, OUT and WB; in_ready SHALL be 1 only in IDLE.
REQ-014 A sample SHALL be accepted on in_valid && in_ready; acceptance SHALL capture in_ch, A, B and a snapshot of all seven weights, then move to HID.
REQ-015 In HID, the block SHALL compute unsigned h1 = theta1*A + beta1 and h2 = theta2*B + beta2 at 2*DATA_W+1 bits, then move to OUT.
REQ-016 In OUT, the block SHALL compute score = alpha1*h1 + alpha2*h2 at 3*DATA_W+2 bits with no truncation, set det = (score >= thresh << DATA_W), then move to WB.
REQ-017 In WB, if the step qualifies (REQ-025), the selected counter SHALL increment and step_pulse SHALL assert that cycle; the FSM SHALL then return to IDLE.
REQ-018 Accept-to-pulse latency SHALL be exactly 3 cycles; sustained throughput SHALL be one sample per 4 cycles.
REQ-019 Counters SHALL saturate at 2^CNT_W-1 and never wrap; at saturation, step_pulse SHALL still assert.
REQ-020 If clr_ch_en hits the channel incremented in the same WB cycle, the clear SHALL win and the counter SHALL read 0.
REQ-021 An in_ch value >= NUM_CH SHALL be processed through the FSM with no counter change and no step_pulse.
REQ-022 Weight writes during HID/OUT/WB SHALL NOT affect the in-flight sample.

Reset
REQ-023 While reset is high: FSM to IDLE; all counters, weights and edge-state bits to 0; step_pulse = 0; step_ch = 0; busy = 0; in_ready = 0.
REQ-024 Reset mid-operation SHALL discard the in-flight sample with no count and no pulse; in_ready SHALL be 1 on the first cycle after reset deasserts.

Configuration
REQ-025 With PEDO_EDGE_DETECT_EN defined, a per-channel prev_det bit SHALL be kept; a step counts only when det=1 and prev_det=0, and prev_det updates to det in WB. Without the macro, every det=1 SHALL count and no prev_det state SHALL exist.

Structure
REQ-026 A shared package pedometer_pkg SHALL hold the FSM state encoding, the weight-index constants (THETA1..THRESH) and the width-derivation functions.
REQ-027 Sub-module ped_weight_file SHALL implement the dual-write 8-entry weight file with port-2 priority; the datapath and FSM SHALL stay in multi_pedometer.

Verification
REQ-028 Write theta1=16, alpha1=16, thresh=16, all other weights 0; send A=16, ch0 -> score 4096, step_pulse at accept+3 with step_ch=0, count0=1.
REQ-029 Same weights, A=15 -> score 3840, no pulse, count0 unchanged.
REQ-030 Under PEDO_EDGE_DETECT_EN, send A=16 three times on ch1 -> count1=1; send A=0, then A=16 -> count1=2. Without the macro, the same stimulus -> count1=4.
REQ-031 Preload count2 to 65534, send two qualifying samples -> 65535 then 65535, with both pulses asserted.
REQ-032 Both write ports target Addr 6 with Data1=5 and Data2=9 -> thresh=9; a write of thresh during HID leaves the in-flight result unchanged.
REQ-033 Assert reset in OUT -> no pulse, all counters 0, in_ready=1 on the cycle after deassertion; a WB increment on ch3 with a simultaneous clr_ch=3 -> count3=0.
